// File: rtl/gpio_in_cond_pkg.sv
// Shared constants and helpers for the GPIO pad-side input conditioning block.
package gpio_in_cond_pkg;

  localparam int unsigned GPIO_WIDTH_DEF = 16;
  localparam int unsigned DEBOUNCE_W_DEF = 8;

  // IRQ_POL encodings
  localparam logic EDGE_RISE = 1'b0;
  localparam logic EDGE_FALL = 1'b1;

  // An update event carries the new stable value; it matches the selected polarity when it
  // equals the level the edge moves towards.
  function automatic logic edge_hit(input logic new_level, input logic pol);
    return (pol == EDGE_RISE) ? new_level : ~new_level;
  endfunction

endpackage

// File: rtl/gpio_db_bit.sv
// One GPIO input bit: two-flop synchroniser, debounce counter and stable-value update pulse.
module gpio_db_bit
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_W = DEBOUNCE_W_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  pad_i,
  input  logic [DEBOUNCE_W-1:0] db_limit_i,
  output logic                  sync_o,
  output logic                  stable_o,
  output logic                  update_o
);

  localparam logic [DEBOUNCE_W-1:0] CntOne = DEBOUNCE_W'(1);

  logic                  sync1_q;
  logic                  sync2_q;
  logic                  stable_q, stable_d;
  logic [DEBOUNCE_W-1:0] cnt_q, cnt_d;
  logic                  mismatch;
  logic                  update;

  assign mismatch = sync2_q ^ stable_q;
  // >= lets a limit lowered mid-count take effect at once; cnt never passes the limit.
  assign update   = mismatch && (cnt_q >= db_limit_i);

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (!mismatch) begin
      cnt_d = '0;
    end else if (update) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntOne;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pad_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign sync_o   = sync2_q;
  assign stable_o = stable_q;
  assign update_o = update;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO pad conditioning: output pass-through, synchronised/debounced inputs, edge interrupts.
// Optional GPIO_IRQ_BOTH_EDGE_EN adds IRQ_BOTH for per-bit both-edge interrupts.
module gpio_in_cond
  import gpio_in_cond_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = GPIO_WIDTH_DEF,
  parameter int unsigned DEBOUNCE_W = DEBOUNCE_W_DEF
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [GPIO_WIDTH-1:0] DIR,
  input  logic [GPIO_WIDTH-1:0] WDATA,
  output logic [GPIO_WIDTH-1:0] RDATA,
  input  logic [GPIO_WIDTH-1:0] PAD_IN,
  output logic [GPIO_WIDTH-1:0] PAD_OUT,
  output logic [GPIO_WIDTH-1:0] PAD_OE,
  input  logic [DEBOUNCE_W-1:0] DB_LIMIT,
  input  logic [GPIO_WIDTH-1:0] IRQ_EN,
  input  logic [GPIO_WIDTH-1:0] IRQ_POL,
`ifdef GPIO_IRQ_BOTH_EDGE_EN
  input  logic [GPIO_WIDTH-1:0] IRQ_BOTH,
`endif
  input  logic [GPIO_WIDTH-1:0] IRQ_CLR,
  output logic [GPIO_WIDTH-1:0] IRQ_PEND,
  output logic                  IRQ
);

  logic [GPIO_WIDTH-1:0] sync;
  logic [GPIO_WIDTH-1:0] stable;
  logic [GPIO_WIDTH-1:0] update;
  logic [GPIO_WIDTH-1:0] pol_hit;
  logic [GPIO_WIDTH-1:0] any_edge;
  logic [GPIO_WIDTH-1:0] irq_set;
  logic [GPIO_WIDTH-1:0] pend_q, pend_d;

  for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_bit
    gpio_db_bit #(
      .DEBOUNCE_W (DEBOUNCE_W)
    ) u_db (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .pad_i      (PAD_IN[i]),
      .db_limit_i (DB_LIMIT),
      .sync_o     (sync[i]),
      .stable_o   (stable[i]),
      .update_o   (update[i])
    );
  end

  assign PAD_OUT = WDATA;
  assign PAD_OE  = DIR;
  assign RDATA   = (DIR & WDATA) | (~DIR & stable);

`ifdef GPIO_IRQ_BOTH_EDGE_EN
  assign any_edge = IRQ_BOTH;
`else
  assign any_edge = '0;
`endif

  always_comb begin
    pol_hit = '0;
    for (int unsigned i = 0; i < GPIO_WIDTH; i++) begin
      pol_hit[i] = edge_hit(sync[i], IRQ_POL[i]);
    end
  end

  // Output bits never raise events, but their debounce state keeps tracking the pad.
  assign irq_set = update & ~DIR & (pol_hit | any_edge);
  // Set wins over a clear in the same cycle.
  assign pend_d  = (pend_q & ~IRQ_CLR) | irq_set;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  assign IRQ_PEND = pend_q;
  assign IRQ      = |(pend_q & IRQ_EN);

endmodule
